// File: rtl/cc1200_pkg.sv
// Shared definitions for the CC1200-style SPI responder: FSM encoding,
// command-strobe address window and header field positions.
package cc1200_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } spi_state_e;

    localparam int ADDR_W = 6;

    localparam logic [ADDR_W-1:0] STROBE_LO = 6'h30;
    localparam logic [ADDR_W-1:0] STROBE_HI = 6'h3D;

    localparam int HDR_RW_BIT    = 7;
    localparam int HDR_BURST_BIT = 6;
    localparam int HDR_ADDR_MSB  = 5;

    function automatic logic is_strobe(input logic [ADDR_W-1:0] a);
        return (a >= STROBE_LO) && (a <= STROBE_HI);
    endfunction

endpackage

// File: rtl/cc1200_sync.sv
// Two-flop synchronizer for an asynchronous input, with a third stage
// used only to detect rising and falling edges of the synchronized level.
module cc1200_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] stages;

    // NOTE: flops use <= so each stage captures the pre-edge value of the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[1:0], async_in};
        end
    end

    assign sync_out = stages[1];
    assign rise     = stages[1] & ~stages[2];
    assign fall     = ~stages[1] & stages[2];

endmodule

// File: rtl/cc1200_spi_responder.sv
// SPI mode-0 responder: status byte on every header slot, register file
// with single/burst access, and command-strobe decoding.
module cc1200_spi_responder
    import cc1200_pkg::*;
#(
    parameter logic [3:0] STATUS_DEFAULT = 4'h0,
    parameter int         NUM_REGS       = 47
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       miso_oe,
    input  logic [2:0] chip_state,
    input  logic       chip_rdy_n,
    output logic       strobe,
    output logic [5:0] strobe_addr,
    output logic       reg_we,
    output logic [5:0] reg_waddr,
    output logic [7:0] reg_wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_level, cs_fall, cs_rise_unused;
    logic [1:0] mosi_ff;
    logic mosi_s;

    cc1200_sync u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .sync_out (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // Resetting the cs_n stages low means a reset mid-frame produces no
    // falling edge, so the aborted frame is ignored until cs_n cycles.
    cc1200_sync u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cs_n),
        .sync_out (cs_level),
        .rise     (cs_rise_unused),
        .fall     (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_ff <= '0;
        end else begin
            mosi_ff <= {mosi_ff[0], mosi};
        end
    end
    assign mosi_s = mosi_ff[1];

    spi_state_e        state, state_next;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_shift;
    logic [7:0]        tx_shift, tx_next;
    logic              load_pending;
    logic [ADDR_W-1:0] addr, addr_inc, hdr_addr;
    logic              is_read, is_burst, byte_done;
    logic [7:0]        rx_byte, hdr_rdata, inc_rdata, status_byte;
    logic [7:0]        regs [NUM_REGS];

    assign status_byte = {chip_rdy_n, chip_state, STATUS_DEFAULT};
    assign miso        = miso_oe & tx_shift[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_next = state;
        rx_byte    = {rx_shift, mosi_s};
        hdr_addr   = rx_byte[HDR_ADDR_MSB:0];
        byte_done  = sclk_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
        addr_inc   = (addr == LAST_ADDR) ? '0 : addr + 6'd1;
        hdr_rdata  = (hdr_addr <= LAST_ADDR) ? regs[hdr_addr] : 8'h00;
        inc_rdata  = (addr_inc <= LAST_ADDR) ? regs[addr_inc] : 8'h00;

        if (cs_level) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (cs_fall) state_next = ST_HEADER;
                ST_HEADER: if (byte_done && !is_strobe(hdr_addr)) state_next = ST_DATA;
                ST_DATA:   if (byte_done && !is_burst) state_next = ST_HEADER;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_next      <= '0;
            load_pending <= 1'b0;
            addr         <= '0;
            is_read      <= 1'b0;
            is_burst     <= 1'b0;
            miso_oe      <= 1'b0;
            strobe       <= 1'b0;
            strobe_addr  <= '0;
            reg_we       <= 1'b0;
            reg_waddr    <= '0;
            reg_wdata    <= '0;
            // NOTE: the register file must come up as all zeros, so it is cleared here and stays in flops.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            strobe <= 1'b0;
            reg_we <= 1'b0;
            if (cs_level || state == ST_IDLE) begin
                bit_cnt      <= '0;
                rx_shift     <= '0;
                load_pending <= 1'b0;
                miso_oe      <= !cs_level && cs_fall;
                tx_shift     <= (!cs_level && cs_fall) ? status_byte : 8'h00;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    load_pending <= 1'b1;
                    if (state == ST_HEADER) begin
                        is_read  <= rx_byte[HDR_RW_BIT];
                        is_burst <= rx_byte[HDR_BURST_BIT];
                        addr     <= hdr_addr;
                        if (is_strobe(hdr_addr)) begin
                            strobe      <= 1'b1;
                            strobe_addr <= hdr_addr;
                            tx_next     <= status_byte;
                        end else begin
                            tx_next <= rx_byte[HDR_RW_BIT] ? hdr_rdata : status_byte;
                        end
                    end else begin
                        if (!is_read && addr <= LAST_ADDR) begin
                            regs[addr] <= rx_byte;
                            reg_we     <= 1'b1;
                            reg_waddr  <= addr;
                            reg_wdata  <= rx_byte;
                        end
                        if (is_burst) begin
                            addr    <= addr_inc;
                            tx_next <= is_read ? inc_rdata : status_byte;
                        end else begin
                            tx_next <= status_byte;
                        end
                    end
                end else if (sclk_fall) begin
                    // The byte chosen at the 8th rise is presented on the following fall.
                    if (load_pending) begin
                        tx_shift     <= tx_next;
                        load_pending <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cc1200_spi_responder.sv
// Self-checking bench: directed SPI frames plus random frames scored against
// a byte-level model of the register file, strobes and status slots.
module tb_cc1200_spi_responder;

    localparam int NUM_REGS = 47;
    localparam int HALF     = 6;

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, cs_n, chip_rdy_n;
    logic [2:0] chip_state;
    wire        miso, miso_oe, strobe, reg_we;
    wire  [5:0] strobe_addr, reg_waddr;
    wire  [7:0] reg_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    int idle_fail_prints = 0;

    logic [7:0]  mem [64];
    logic [7:0]  tx_q[$], rx_q[$], exp_q[$];
    bit          care_q[$];
    logic [13:0] wr_q[$], exp_wr_q[$];
    logic [5:0]  st_q[$], exp_st_q[$];
    logic        oe_mid, oe_after;

    cc1200_spi_responder #(
        .STATUS_DEFAULT (4'h0),
        .NUM_REGS       (NUM_REGS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .chip_state  (chip_state),
        .chip_rdy_n  (chip_rdy_n),
        .strobe      (strobe),
        .strobe_addr (strobe_addr),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (reg_we) wr_q.push_back({reg_waddr, reg_wdata});
        if (strobe) st_q.push_back(strobe_addr);
        if (!miso_oe) begin
            n_cmp++;
            if (miso !== 1'b0) begin
                n_bad++;
                if (idle_fail_prints < 5)
                    $display("FAIL miso_idle: miso=%b while miso_oe low, required 0", miso);
                idle_fail_prints++;
            end
        end
    end

    function automatic logic [7:0] status_now();
        return {chip_rdy_n, chip_state, 4'h0};
    endfunction

    function automatic logic [7:0] rd_model(input logic [5:0] a);
        return (int'(a) < NUM_REGS) ? mem[a] : 8'h00;
    endfunction

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame();
        logic [7:0] r;
        rx_q.delete(); wr_q.delete(); st_q.delete();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        foreach (tx_q[k]) begin
            xfer_bits(tx_q[k], 8, r);
            rx_q.push_back(r);
        end
        repeat (HALF) @(negedge clk);
        oe_mid = miso_oe;
        cs_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        oe_after = miso_oe;
    endtask

    // Walks the frame byte by byte: header slots answer with status, reads
    // return the addressed register (0 outside the map), writes update mem.
    task automatic model_frame();
        logic       hdr, rd, bu;
        logic [5:0] a;
        logic [7:0] b, st;
        exp_q.delete(); care_q.delete(); exp_wr_q.delete(); exp_st_q.delete();
        st = status_now();
        hdr = 1'b1; rd = 1'b0; bu = 1'b0; a = '0;
        exp_q.push_back(st); care_q.push_back(1'b1);
        foreach (tx_q[k]) begin
            b = tx_q[k];
            if (hdr) begin
                a = b[5:0]; rd = b[7]; bu = b[6];
                if (a >= 6'h30 && a <= 6'h3D) begin
                    exp_st_q.push_back(a);
                    exp_q.push_back(st); care_q.push_back(1'b1);
                end else begin
                    hdr = 1'b0;
                    exp_q.push_back(rd ? rd_model(a) : 8'h00); care_q.push_back(rd);
                end
            end else begin
                if (!rd && int'(a) < NUM_REGS) begin
                    mem[a] = b;
                    exp_wr_q.push_back({a, b});
                end
                if (bu) begin
                    a = (int'(a) == NUM_REGS - 1) ? 6'd0 : a + 6'd1;
                    exp_q.push_back(rd ? rd_model(a) : 8'h00); care_q.push_back(rd);
                end else begin
                    hdr = 1'b1;
                    exp_q.push_back(st); care_q.push_back(1'b1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({miso, miso_oe} !== 2'b00) begin n_bad++; $display("FAIL reset_miso: miso/oe=%b required 00", {miso, miso_oe}); end
        n_cmp++; if ({strobe, reg_we} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: strobe/we=%b required 00", {strobe, reg_we}); end
        n_cmp++; if (strobe_addr !== 6'h00) begin n_bad++; $display("FAIL reset_strobe_addr: %h required 00", strobe_addr); end
        n_cmp++; if ({reg_waddr, reg_wdata} !== 14'h0) begin n_bad++; $display("FAIL reset_wbus: %h/%h required 00/00", reg_waddr, reg_wdata); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    task automatic test_single_write();
        chip_rdy_n = 1'b1; chip_state = 3'b101;
        tx_q = '{8'h05, 8'hA5};
        run_frame(); model_frame();
        n_cmp++; if (rx_q[0] !== 8'hD0) begin n_bad++; $display("FAIL wr_status: got %h required D0", rx_q[0]); end
        n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL wr_count: got %0d required 1", wr_q.size()); end
        n_cmp++; if (wr_q.size() > 0 && wr_q[0] !== {6'h05, 8'hA5}) begin n_bad++; $display("FAIL wr_entry: got %h required %h", wr_q[0], {6'h05, 8'hA5}); end
        n_cmp++; if (st_q.size() != 0) begin n_bad++; $display("FAIL wr_strobe: got %0d strobes required 0", st_q.size()); end
        n_cmp++; if (oe_mid !== 1'b1) begin n_bad++; $display("FAIL oe_in_frame: got %b required 1", oe_mid); end
        n_cmp++; if (oe_after !== 1'b0) begin n_bad++; $display("FAIL oe_after_frame: got %b required 0", oe_after); end
    endtask

    task automatic test_single_read();
        tx_q = '{8'h85, 8'h00, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (rx_q[1] !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h required A5", rx_q[1]); end
        n_cmp++; if (rx_q[2] !== 8'hD0) begin n_bad++; $display("FAIL rd_next_status: got %h required D0", rx_q[2]); end
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL rd_no_write: got %0d writes required 0", wr_q.size()); end
    endtask

    task automatic test_burst();
        logic [13:0] want [3];
        want = '{{6'h2D, 8'h11}, {6'h2E, 8'h22}, {6'h00, 8'h33}};
        chip_rdy_n = 1'b0; chip_state = 3'b001;
        tx_q = '{8'h6D, 8'h11, 8'h22, 8'h33};
        run_frame(); model_frame();
        n_cmp++; if (wr_q.size() != 3) begin n_bad++; $display("FAIL burst_wr_count: got %0d required 3", wr_q.size()); end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            n_cmp++; if (wr_q[i] !== want[i]) begin n_bad++; $display("FAIL burst_wr[%0d]: got %h required %h", i, wr_q[i], want[i]); end
        end
        tx_q = '{8'hED, 8'h00, 8'h00, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (rx_q[0] !== 8'h10) begin n_bad++; $display("FAIL burst_status: got %h required 10", rx_q[0]); end
        n_cmp++; if (rx_q[1] !== 8'h11) begin n_bad++; $display("FAIL burst_rd0: got %h required 11", rx_q[1]); end
        n_cmp++; if (rx_q[2] !== 8'h22) begin n_bad++; $display("FAIL burst_rd1: got %h required 22", rx_q[2]); end
        n_cmp++; if (rx_q[3] !== 8'h33) begin n_bad++; $display("FAIL burst_rd_wrap: got %h required 33", rx_q[3]); end
    endtask

    task automatic test_strobe();
        chip_rdy_n = 1'b1; chip_state = 3'b000;
        tx_q = '{8'h36, 8'h30, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (st_q.size() != 2) begin n_bad++; $display("FAIL strobe_count: got %0d required 2", st_q.size()); end
        n_cmp++; if (st_q.size() > 0 && st_q[0] !== 6'h36) begin n_bad++; $display("FAIL strobe_addr0: got %h required 36", st_q[0]); end
        n_cmp++; if (st_q.size() > 1 && st_q[1] !== 6'h30) begin n_bad++; $display("FAIL strobe_addr1: got %h required 30", st_q[1]); end
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL strobe_no_write: got %0d required 0", wr_q.size()); end
        n_cmp++; if (rx_q[1] !== 8'h80) begin n_bad++; $display("FAIL strobe_slot1: got %h required 80", rx_q[1]); end
        n_cmp++; if (rx_q[2] !== 8'h80) begin n_bad++; $display("FAIL strobe_slot2: got %h required 80", rx_q[2]); end
    endtask

    task automatic test_status();
        chip_rdy_n = 1'b0; chip_state = 3'b010;
        tx_q = '{8'h3D, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (rx_q[0] !== 8'h20) begin n_bad++; $display("FAIL status_first: got %h required 20", rx_q[0]); end
        n_cmp++; if (rx_q[1] !== 8'h20) begin n_bad++; $display("FAIL status_after_snop: got %h required 20", rx_q[1]); end
        n_cmp++; if (st_q.size() != 1 || st_q[0] !== 6'h3D) begin n_bad++; $display("FAIL status_strobe_hi: got %0d strobes required one at 3D", st_q.size()); end
    endtask

    task automatic test_invalid();
        chip_rdy_n = 1'b1; chip_state = 3'b011;
        tx_q = '{8'h2F, 8'h77, 8'h3E, 8'h66, 8'hBF, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL invalid_no_write: got %0d required 0", wr_q.size()); end
        n_cmp++; if (st_q.size() != 0) begin n_bad++; $display("FAIL invalid_no_strobe: got %0d required 0", st_q.size()); end
        n_cmp++; if (rx_q[2] !== 8'hB0) begin n_bad++; $display("FAIL invalid_slot2: got %h required B0", rx_q[2]); end
        n_cmp++; if (rx_q[4] !== 8'hB0) begin n_bad++; $display("FAIL invalid_slot4: got %h required B0", rx_q[4]); end
        n_cmp++; if (rx_q[5] !== 8'h00) begin n_bad++; $display("FAIL invalid_read: got %h required 00", rx_q[5]); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        tx_q = '{8'h07, 8'h3C};
        run_frame(); model_frame();
        wr_q.delete(); st_q.delete();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer_bits(8'h07, 8, r);
        xfer_bits(8'hFF, 5, r);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL abort_no_write: got %0d required 0", wr_q.size()); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL abort_oe: got %b required 0", miso_oe); end
        tx_q = '{8'h87, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (rx_q[1] !== 8'h3C) begin n_bad++; $display("FAIL abort_reg_kept: got %h required 3C", rx_q[1]); end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 40; f++) begin
            chip_rdy_n = 1'($urandom_range(0, 1));
            chip_state = 3'($urandom_range(0, 7));
            tx_q.delete();
            tx_q.push_back({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, NUM_REGS - 1))});
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            run_frame(); model_frame();
            for (int k = 0; k < rx_q.size(); k++) begin
                if (care_q[k]) begin
                    n_cmp++;
                    if (rx_q[k] !== exp_q[k]) begin
                        n_bad++;
                        $display("FAIL rand_miso f%0d b%0d: got %h required %h", f, k, rx_q[k], exp_q[k]);
                    end
                end
            end
            n_cmp++;
            if (wr_q != exp_wr_q) begin
                n_bad++;
                $display("FAIL rand_writes f%0d: got %0d writes required %0d (or contents differ)", f, wr_q.size(), exp_wr_q.size());
            end
            n_cmp++;
            if (st_q != exp_st_q) begin
                n_bad++;
                $display("FAIL rand_strobes f%0d: got %0d strobes required %0d (or addrs differ)", f, st_q.size(), exp_st_q.size());
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        logic       oe_rem;
        tx_q = '{8'h0A, 8'h5A};
        run_frame(); model_frame();
        wr_q.delete(); st_q.delete();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer_bits(8'h0A, 8, r);
        xfer_bits(8'hC3, 4, r);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        xfer_bits(8'h30, 4, r);
        xfer_bits(8'h36, 8, r);
        repeat (HALF) @(negedge clk);
        oe_rem = miso_oe;
        cs_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL rstmid_no_write: got %0d required 0", wr_q.size()); end
        n_cmp++; if (st_q.size() != 0) begin n_bad++; $display("FAIL rstmid_no_strobe: got %0d required 0", st_q.size()); end
        n_cmp++; if (oe_rem !== 1'b0) begin n_bad++; $display("FAIL rstmid_oe: got %b required 0", oe_rem); end
        chip_rdy_n = 1'b1; chip_state = 3'b110;
        tx_q = '{8'h8A, 8'h00};
        run_frame(); model_frame();
        n_cmp++; if (rx_q[0] !== 8'hE0) begin n_bad++; $display("FAIL rstmid_status: got %h required E0", rx_q[0]); end
        n_cmp++; if (rx_q[1] !== 8'h00) begin n_bad++; $display("FAIL rstmid_reg_cleared: got %h required 00", rx_q[1]); end
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        chip_rdy_n = 1'b1; chip_state = 3'b000;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst();
        test_strobe();
        test_status();
        test_invalid();
        test_abort();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
